// File: rtl/logic_axi4_stream_demux_pkg.sv
// Shared types for the two-way AXI4-Stream demux: FSM state, port index,
// and a helper that keeps disabled stream fields at a legal 1-bit width.
package logic_axi4_stream_demux_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic {
    FIRST = 1'b0,
    BODY  = 1'b1
  } state_t;

  typedef logic [0:0] port_idx_t;

  // Disabled fields still need a physical bit so the interface stays legal.
  function automatic int unsigned field_w(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle used on both sides of the demux; widths of disabled
// fields collapse to one bit and are tied off by the producer.
interface logic_axi4_stream_if #(
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
);
  import logic_axi4_stream_demux_pkg::*;

  localparam int unsigned DW  = field_w(TDATA_BYTES * 8);
  localparam int unsigned KW  = field_w(TDATA_BYTES);
  localparam int unsigned DSW = field_w(TDEST_WIDTH);
  localparam int unsigned UW  = field_w(TUSER_WIDTH);
  localparam int unsigned IW  = field_w(TID_WIDTH);

  logic           tvalid;
  logic           tready;
  logic [DW-1:0]  tdata;
  logic [KW-1:0]  tkeep;
  logic [KW-1:0]  tstrb;
  logic           tlast;
  logic [UW-1:0]  tuser;
  logic [DSW-1:0] tdest;
  logic [IW-1:0]  tid;

  modport rx (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );

  modport tx (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

endinterface

// File: rtl/logic_axi4_stream_demux_output.sv
// One registered Tx slot: holds a beat until the sink takes it and applies
// the constant tie-offs for any stream field that is compiled out.
module logic_axi4_stream_demux_output
  import logic_axi4_stream_demux_pkg::*;
#(
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned TLAST       = 1,
  localparam int unsigned DW  = field_w(TDATA_BYTES * 8),
  localparam int unsigned KW  = field_w(TDATA_BYTES),
  localparam int unsigned DSW = field_w(TDEST_WIDTH),
  localparam int unsigned UW  = field_w(TUSER_WIDTH),
  localparam int unsigned IW  = field_w(TID_WIDTH)
) (
  input  logic           aclk,
  input  logic           areset_n,
  input  logic           load,
  input  logic [DW-1:0]  beat_tdata,
  input  logic [KW-1:0]  beat_tkeep,
  input  logic           beat_tlast,
  input  logic [UW-1:0]  beat_tuser,
  input  logic [DSW-1:0] beat_tdest,
  input  logic [IW-1:0]  beat_tid,
  input  logic           tready,
  output logic           tvalid,
  output logic [DW-1:0]  tdata,
  output logic [KW-1:0]  tkeep,
  output logic [KW-1:0]  tstrb,
  output logic           tlast,
  output logic [UW-1:0]  tuser,
  output logic [DSW-1:0] tdest,
  output logic [IW-1:0]  tid
);

  logic           tvalid_q;
  logic [DW-1:0]  tdata_q;
  logic [KW-1:0]  tkeep_q;
  logic           tlast_q;
  logic [UW-1:0]  tuser_q;
  logic [DSW-1:0] tdest_q;
  logic [IW-1:0]  tid_q;

  // A load wins over a drain so a same-cycle drain+load keeps tvalid high.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tvalid_q <= 1'b0;
    end else if (load) begin
      tvalid_q <= 1'b1;
    end else if (tready) begin
      tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (load) begin
      tdata_q <= beat_tdata;
      tkeep_q <= beat_tkeep;
      tlast_q <= beat_tlast;
      tuser_q <= beat_tuser;
      tdest_q <= beat_tdest;
      tid_q   <= beat_tid;
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = (TDATA_BYTES > 0) ? tdata_q : '0;
  assign tkeep  = (TDATA_BYTES > 0) ? tkeep_q : '1;
  assign tstrb  = tkeep;
  assign tlast  = (TLAST > 0)       ? tlast_q : 1'b1;
  assign tuser  = (TUSER_WIDTH > 0) ? tuser_q : '0;
  assign tdest  = (TDEST_WIDTH > 0) ? tdest_q : '0;
  assign tid    = (TID_WIDTH > 0)   ? tid_q   : '0;

endmodule

// File: rtl/logic_axi4_stream_demux_unit.sv
// Two-way AXI4-Stream demux: routes each packet to tx[tdest[SELECT_BIT]],
// locking the route from the first beat until tlast.
//
//   state | meaning
//   FIRST | next accepted beat starts a packet; route taken from rx.tdest
//   BODY  | inside a packet; beats follow the latched route
module logic_axi4_stream_demux_unit
  import logic_axi4_stream_demux_pkg::*;
#(
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned TLAST       = 1,
  parameter int unsigned SELECT_BIT  = 0
) (
  input logic              aclk,
  input logic              areset_n,
  logic_axi4_stream_if.rx  rx,
  logic_axi4_stream_if.tx  tx [1:0]
);

  state_t                 state_q, state_d;
  port_idx_t              route_q, route_d;
  port_idx_t              r;
  logic                   dest_bit;
  logic                   rx_tlast;
  logic                   accept;
  logic [NUM_PORTS-1:0]   slot_tvalid;
  logic [NUM_PORTS-1:0]   slot_tready;
  logic [NUM_PORTS-1:0]   load;

  generate
    if (TDEST_WIDTH > 0) begin : g_dest
      assign dest_bit = rx.tdest[SELECT_BIT];
    end else begin : g_no_dest
      assign dest_bit = 1'b0;
    end
  endgenerate

  assign rx_tlast = (TLAST > 0) ? rx.tlast : 1'b1;

  always_comb begin
    r = port_idx_t'(dest_bit);
    if (TDEST_WIDTH == 0) begin
      r = '0;
    end else if (state_q == BODY) begin
      r = route_q;
    end
  end

  // Only the selected slot gates rx; the other port drains on its own.
  assign rx.tready = !slot_tvalid[r] || slot_tready[r];
  assign accept    = rx.tvalid && rx.tready;

  always_comb begin
    load = '0;
    load[r] = accept;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= FIRST;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (TLAST > 0 && accept) begin
      case (state_q)
        FIRST: begin
          if (!rx_tlast) begin
            route_d = r;
            state_d = BODY;
          end
        end
        BODY: begin
          if (rx_tlast) begin
            state_d = FIRST;
          end
        end
        default: state_d = FIRST;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic_axi4_stream_demux_output #(
        .TDATA_BYTES (TDATA_BYTES),
        .TDEST_WIDTH (TDEST_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH),
        .TID_WIDTH   (TID_WIDTH),
        .TLAST       (TLAST)
      ) u_slot (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .load       (load[i]),
        .beat_tdata (rx.tdata),
        .beat_tkeep (rx.tkeep),
        .beat_tlast (rx.tlast),
        .beat_tuser (rx.tuser),
        .beat_tdest (rx.tdest),
        .beat_tid   (rx.tid),
        .tready     (tx[i].tready),
        .tvalid     (tx[i].tvalid),
        .tdata      (tx[i].tdata),
        .tkeep      (tx[i].tkeep),
        .tstrb      (tx[i].tstrb),
        .tlast      (tx[i].tlast),
        .tuser      (tx[i].tuser),
        .tdest      (tx[i].tdest),
        .tid        (tx[i].tid)
      );
      assign slot_tvalid[i] = tx[i].tvalid;
      assign slot_tready[i] = tx[i].tready;
    end
  endgenerate

endmodule

// File: tb/tb_logic_axi4_stream_demux_unit.sv
// Scoreboard bench: stimulus pushes expected beats per Tx port, a negedge
// monitor pops and compares on every Tx handshake.
`timescale 1ns/1ps
module tb_logic_axi4_stream_demux_unit;
  import logic_axi4_stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // dut_a: full-featured, 2-bit tdest, bit 0 selects the port
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) rxa ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) txa [1:0] ();
  // dut_b: no tlast, no tdest, 32-bit data
  logic_axi4_stream_if #(.TDATA_BYTES(4), .TDEST_WIDTH(0), .TUSER_WIDTH(1), .TID_WIDTH(1)) rxb ();
  logic_axi4_stream_if #(.TDATA_BYTES(4), .TDEST_WIDTH(0), .TUSER_WIDTH(1), .TID_WIDTH(1)) txb [1:0] ();

  logic_axi4_stream_demux_unit #(
    .TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1), .TLAST(1), .SELECT_BIT(0)
  ) dut_a (.aclk(clk), .areset_n(rst_n), .rx(rxa), .tx(txa));

  logic_axi4_stream_demux_unit #(
    .TDATA_BYTES(4), .TDEST_WIDTH(0), .TUSER_WIDTH(1), .TID_WIDTH(1), .TLAST(0), .SELECT_BIT(0)
  ) dut_b (.aclk(clk), .areset_n(rst_n), .rx(rxb), .tx(txb));

  logic [10:0] qa0[$];
  logic [10:0] qa1[$];
  logic [35:0] qb[$];
  int          hs_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_a(input int port, input logic [10:0] act);
    logic [10:0] e;
    if ((port == 0 && qa0.size() == 0) || (port == 1 && qa1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_unexpected_beat port %0d: got %0h expected none", port, act);
      return;
    end
    if (port == 0) e = qa0.pop_front();
    else e = qa1.pop_front();
    chk($sformatf("a_beat_port%0d", port), act, e);
  endtask

  // Monitor: Tx handshakes complete at the next posedge, so sample on negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (txa[0].tvalid && txa[0].tready) begin
        hs_cyc.push_back(cyc);
        pop_a(0, {txa[0].tlast, txa[0].tdest, txa[0].tdata});
      end
      if (txa[1].tvalid && txa[1].tready) begin
        hs_cyc.push_back(cyc);
        pop_a(1, {txa[1].tlast, txa[1].tdest, txa[1].tdata});
      end
      if (txb[0].tvalid && txb[0].tready) begin
        if (qb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_beat: got %0h expected none", txb[0].tdata);
        end else begin
          chk("b_beat", {txb[0].tkeep, txb[0].tdata}, qb.pop_front());
          chk("b_tlast", txb[0].tlast, 1);
          chk("b_tdest", txb[0].tdest, 0);
          chk("b_tstrb", txb[0].tstrb, txb[0].tkeep);
        end
      end
      if (txb[1].tvalid) chk("b_tx1_valid", txb[1].tvalid, 0);
    end
  end

  task automatic idle(input int n);
    rxa.tvalid = 1'b0;
    rxb.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat on rxa and returns 1 time unit after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic [1:0] dest, input logic last,
                        input int port, input bit expect_out, output int waited);
    rxa.tdata = d; rxa.tdest = dest; rxa.tlast = last;
    rxa.tkeep = 1'b1; rxa.tstrb = 1'b1; rxa.tuser = 1'b0; rxa.tid = 1'b0;
    rxa.tvalid = 1'b1;
    if (expect_out) begin
      if (port == 0) qa0.push_back({last, dest, d});
      else qa1.push_back({last, dest, d});
    end
    waited = 0;
    @(negedge clk);
    while (!rxa.tready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!rxa.tready) chk("a_send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ready_b();
    txb[0].tready = 1'($urandom_range(0, 1));
    txb[1].tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_b(input logic [31:0] d, input logic [3:0] k, input logic dst, input logic last);
    int w;
    w = 0;
    rxb.tdata = d; rxb.tkeep = k; rxb.tstrb = k; rxb.tdest = dst; rxb.tlast = last;
    rxb.tuser = 1'b0; rxb.tid = 1'b0;
    rxb.tvalid = 1'b1;
    qb.push_back({k, d});
    @(negedge clk);
    while (!rxb.tready && w < 200) begin
      @(posedge clk); #1;
      rand_ready_b();
      w++;
      @(negedge clk);
    end
    if (!rxb.tready) chk("b_send_timeout", 0, 1);
    @(posedge clk); #1;
    rand_ready_b();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rxa.tvalid = 0; rxa.tdata = 0; rxa.tkeep = 1; rxa.tstrb = 1; rxa.tlast = 0;
    rxa.tuser = 0; rxa.tdest = 0; rxa.tid = 0;
    rxb.tvalid = 0; rxb.tdata = 0; rxb.tkeep = 0; rxb.tstrb = 0; rxb.tlast = 0;
    rxb.tuser = 0; rxb.tdest = 0; rxb.tid = 0;
    txa[0].tready = 1; txa[1].tready = 1;
    txb[0].tready = 1; txb[1].tready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_tvalid0", txa[0].tvalid, 0);
    chk("rst_a_tvalid1", txa[1].tvalid, 0);
    chk("rst_b_tvalid0", txb[0].tvalid, 0);
    chk("rst_a_state", dut_a.state_q, FIRST);
    chk("rst_a_rx_tready", rxa.tready, 1);
    rst_n = 1'b1;
    idle(2);

    // Single beat: A5 to tx[1], one cycle latency
    send_a(8'hA5, 2'd1, 1'b1, 1, 1, w);
    chk("single_latency_valid", txa[1].tvalid, 1);
    chk("single_data", txa[1].tdata, 8'hA5);
    chk("single_tx0_idle", txa[0].tvalid, 0);
    idle(1);
    chk("single_drained", txa[1].tvalid, 0);
    idle(2);

    // Packet lock: tdest toggles mid-packet, all beats stay on tx[0]
    send_a(8'h10, 2'd0, 1'b0, 0, 1, w);
    chk("lock_state_body", dut_a.state_q, BODY);
    send_a(8'h11, 2'd1, 1'b0, 0, 1, w);
    send_a(8'h12, 2'd0, 1'b0, 0, 1, w);
    send_a(8'h13, 2'd1, 1'b1, 0, 1, w);
    chk("lock_state_first", dut_a.state_q, FIRST);
    idle(3);

    // Back-to-back packets, port switch without a bubble
    hs_cyc.delete();
    send_a(8'h50, 2'd0, 1'b0, 0, 1, w); chk("b2b_rdy0", w, 0);
    send_a(8'h51, 2'd2, 1'b0, 0, 1, w); chk("b2b_rdy1", w, 0);
    send_a(8'h52, 2'd0, 1'b1, 0, 1, w); chk("b2b_rdy2", w, 0);
    send_a(8'h60, 2'd3, 1'b0, 1, 1, w); chk("b2b_rdy3", w, 0);
    send_a(8'h61, 2'd1, 1'b1, 1, 1, w); chk("b2b_rdy4", w, 0);
    idle(3);
    chk("b2b_beat_count", hs_cyc.size(), 5);
    if (hs_cyc.size() == 5) chk("b2b_no_bubble", hs_cyc[4] - hs_cyc[0], 4);

    // Independent backpressure
    txa[0].tready = 1'b0;
    send_a(8'h20, 2'd0, 1'b1, 0, 1, w);
    chk("bp_first_rdy", w, 0);
    rxa.tdata = 8'h21; rxa.tdest = 2'd0; rxa.tlast = 1'b1; rxa.tvalid = 1'b1;
    qa0.push_back({1'b1, 2'd0, 8'h21});
    repeat (3) begin
      @(negedge clk);
      chk("bp_rx_tready_low", rxa.tready, 0);
    end
    chk("bp_hold_data", txa[0].tdata, 8'h20);
    chk("bp_hold_valid", txa[0].tvalid, 1);
    @(posedge clk); #1;
    txa[0].tready = 1'b1;
    @(negedge clk);
    chk("bp_rx_tready_release", rxa.tready, 1);
    @(posedge clk); #1;
    txa[0].tready = 1'b0;
    send_a(8'h22, 2'd1, 1'b1, 1, 1, w);
    chk("bp_other_port_flows", w, 0);
    chk("bp_tx0_holds_valid", txa[0].tvalid, 1);
    chk("bp_tx0_holds_data", txa[0].tdata, 8'h21);
    chk("bp_tx1_valid", txa[1].tvalid, 1);
    rxa.tvalid = 1'b0;
    txa[0].tready = 1'b1;
    idle(3);

    // Mid-packet reset discards held beats
    send_a(8'h30, 2'd1, 1'b0, 1, 1, w);
    send_a(8'h31, 2'd1, 1'b0, 1, 0, w);
    rxa.tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_tvalid0", txa[0].tvalid, 0);
    chk("mrst_tvalid1", txa[1].tvalid, 0);
    chk("mrst_state", dut_a.state_q, FIRST);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send_a(8'h40, 2'd0, 1'b1, 0, 1, w);
    chk("mrst_next_to_tx0", txa[0].tvalid, 1);
    chk("mrst_tx1_idle", txa[1].tvalid, 0);
    idle(3);

    // Parameter sweep: no tlast, no tdest, 32-bit data, random backpressure
    rand_ready_b();
    for (int i = 0; i < 100; i++) begin
      send_b($urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rxb.tvalid = 1'b0;
    txb[0].tready = 1'b1;
    txb[1].tready = 1'b1;
    idle(5);

    chk("end_qa0_empty", qa0.size(), 0);
    chk("end_qa1_empty", qa1.size(), 0);
    chk("end_qb_empty", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
